// File: rtl/ysyx_22040127_mdu_ctrl_pkg.sv
// Shared definitions for the M-extension sequencer: FSM encoding, funct3 codes
// and the most-negative constants used to spot signed divide overflow.
package ysyx_22040127_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_WAIT  = 3'd1,
    S_DIV_WAIT  = 3'd2,
    S_MUL_DRAIN = 3'd3,
    S_DONE      = 3'd4
  } mdu_state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [63:0] XLEN_MIN_64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] XLEN_MIN_32 = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22040127_mdu_special.sv
// Detects divide-by-zero and signed overflow and supplies the architectural
// quotient/remainder for those cases so the divider never has to run.
module ysyx_22040127_mdu_special
  import ysyx_22040127_mdu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            word_i,
  input  logic            signed_i,
  output logic            div0_o,
  output logic            ovf_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] dividend_eff;

  always_comb begin
    // word results are always the sign extension of the low 32 bits
    dividend_eff = word_i ? {{(XLEN-32){dividend_i[31]}}, dividend_i[31:0]} : dividend_i;

    if (word_i) begin
      div0_o = (divisor_i[31:0] == 32'd0);
      ovf_o  = signed_i && (dividend_i[31:0] == XLEN_MIN_32) && (divisor_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      div0_o = (divisor_i == '0);
      ovf_o  = signed_i && (dividend_i == XLEN_MIN_64) && (divisor_i == '1);
    end

    quo_o = '1;
    rem_o = dividend_eff;
    if (!div0_o && ovf_o) begin
      quo_o = dividend_eff;
      rem_o = '0;
    end
  end

endmodule

// File: rtl/ysyx_22040127_mdu_ctrl.sv
// Sequencer between execute and the shared multiplier/divider: accepts one
// M-extension op, launches the right unit, and holds the result for memory.
module ysyx_22040127_mdu_ctrl
  import ysyx_22040127_mdu_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_valid,
  output logic [XLEN-1:0]  mul_src1,
  output logic [XLEN-1:0]  mul_src2,
  output logic             mul_sign1,
  output logic             mul_sign2,
  input  logic             mul_ok,
  input  logic [XLEN-1:0]  mul_res_high,
  input  logic [XLEN-1:0]  mul_res_low,
  output logic             div_valid,
  output logic [XLEN-1:0]  div_src1,
  output logic [XLEN-1:0]  div_src2,
  output logic             div_sign,
  output logic             div_flush,
  input  logic             div_ready,
  input  logic [XLEN-1:0]  div_quo,
  input  logic [XLEN-1:0]  div_rem
);

  mdu_state_e       state_q, state_d;
  logic             start_q, start_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [2:0]       op_q;
  logic             word_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  src1_q, src2_q;
  logic             msign1_q, msign2_q, dsign_q;

  logic             accept;
  logic [XLEN-1:0]  src1_ext, src2_ext;
  logic [XLEN-1:0]  mul_pick, div_raw, div_pick;
  logic             sp_div0, sp_ovf;
  logic [XLEN-1:0]  sp_quo, sp_rem;

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  assign req_ready = (state_q == S_IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    src1_ext = req_src1;
    src2_ext = req_src2;
    if (req_op[2] && req_word) begin
      src1_ext = {{(XLEN-32){req_src1[31] & ~req_op[0]}}, req_src1[31:0]};
      src2_ext = {{(XLEN-32){req_src2[31] & ~req_op[0]}}, req_src2[31:0]};
    end
  end

  always_comb begin
    if (op_q == OP_MUL) begin
      mul_pick = word_q ? sext_w(mul_res_low[31:0]) : mul_res_low;
    end else begin
      mul_pick = mul_res_high;
    end
    div_raw  = op_q[1] ? div_rem : div_quo;
    div_pick = word_q ? sext_w(div_raw[31:0]) : div_raw;
  end

  ysyx_22040127_mdu_special #(
    .XLEN(XLEN)
  ) u_special (
    .dividend_i(src1_q),
    .divisor_i (src2_q),
    .word_i    (word_q),
    .signed_i  (dsign_q),
    .div0_o    (sp_div0),
    .ovf_o     (sp_ovf),
    .quo_o     (sp_quo),
    .rem_o     (sp_rem)
  );

  // start_q marks the launch cycle right after acceptance; the unit is only
  // busy once that cycle has passed without a flush.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_op[2] ? S_DIV_WAIT : S_MUL_WAIT;
          start_d = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        if (flush) begin
          start_d = 1'b0;
          state_d = (start_q || mul_ok) ? S_IDLE : S_MUL_DRAIN;
        end else if (start_q) begin
          start_d = 1'b0;
        end else if (mul_ok) begin
          state_d  = S_DONE;
          result_d = mul_pick;
        end
      end
      S_DIV_WAIT: begin
        if (flush) begin
          start_d = 1'b0;
          state_d = S_IDLE;
        end else if (start_q) begin
          start_d = 1'b0;
          if (sp_div0 || sp_ovf) begin
            state_d  = S_DONE;
            result_d = op_q[1] ? sp_rem : sp_quo;
          end
        end else if (div_ready) begin
          state_d  = S_DONE;
          result_d = div_pick;
        end
      end
      S_MUL_DRAIN: begin
        if (mul_ok) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      result_q <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      tag_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      msign1_q <= 1'b0;
      msign2_q <= 1'b0;
      dsign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      result_q <= result_d;
      if (accept) begin
        op_q     <= req_op;
        word_q   <= req_word;
        tag_q    <= req_tag;
        src1_q   <= src1_ext;
        src2_q   <= src2_ext;
        msign1_q <= (req_op != OP_MULHU);
        msign2_q <= (req_op == OP_MUL) || (req_op == OP_MULH);
        dsign_q  <= ~req_op[0];
      end
    end
  end

  assign mul_valid = (state_q == S_MUL_WAIT) && start_q && !flush && !rst;
  assign div_valid = (state_q == S_DIV_WAIT) && start_q && !flush && !rst && !(sp_div0 || sp_ovf);
  // the divider is only aborted once it has actually been started
  assign div_flush = (state_q == S_DIV_WAIT) && !start_q && flush && !rst;

  assign mul_src1  = src1_q;
  assign mul_src2  = src2_q;
  assign mul_sign1 = msign1_q;
  assign mul_sign2 = msign2_q;
  assign div_src1  = src1_q;
  assign div_src2  = src2_q;
  assign div_sign  = dsign_q;

  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_ysyx_22040127_mdu_ctrl.sv
// Bench for the MDU sequencer: a vector table driven through a scoreboard,
// followed by hand-written flush/reset corner sequences.
module tb_ysyx_22040127_mdu_ctrl;
  import ysyx_22040127_mdu_ctrl_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam int U_FAST = 0;
  localparam int U_MUL  = 1;
  localparam int U_DIV  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_word;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_src1, req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid, resp_ready;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_valid, mul_sign1, mul_sign2, mul_ok;
  logic [XLEN-1:0]  mul_src1, mul_src2, mul_res_high, mul_res_low;
  logic             div_valid, div_sign, div_flush, div_ready;
  logic [XLEN-1:0]  div_src1, div_src2, div_quo, div_rem;

  always #5 clk = ~clk;

  ysyx_22040127_mdu_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_tag(resp_tag),
    .mul_valid(mul_valid), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_sign1(mul_sign1), .mul_sign2(mul_sign2), .mul_ok(mul_ok),
    .mul_res_high(mul_res_high), .mul_res_low(mul_res_low),
    .div_valid(div_valid), .div_src1(div_src1), .div_src2(div_src2), .div_sign(div_sign),
    .div_flush(div_flush), .div_ready(div_ready), .div_quo(div_quo), .div_rem(div_rem)
  );

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] s1, s2;
    logic [4:0]  tag;
    int          unit;
    logic [63:0] e1, e2;   // operands expected at the unit
    logic        sg1, sg2; // mul_sign1/mul_sign2, or div_sign in sg1
    logic [63:0] ua, ub;   // unit response: mul high/low or div quo/rem
    logic [63:0] res;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } sb_t;

  vec_t vq[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] op, input logic word, input logic [63:0] s1, input logic [63:0] s2,
                     input logic [4:0] tag, input int unit, input logic [63:0] e1, input logic [63:0] e2,
                     input logic sg1, input logic sg2, input logic [63:0] ua, input logic [63:0] ub,
                     input logic [63:0] res, input int hold);
    vec_t v;
    v.op = op; v.word = word; v.s1 = s1; v.s2 = s2; v.tag = tag; v.unit = unit;
    v.e1 = e1; v.e2 = e2; v.sg1 = sg1; v.sg2 = sg2; v.ua = ua; v.ub = ub;
    v.res = res; v.hold = hold;
    vq.push_back(v);
  endtask

  // returns in the cycle after acceptance, one time unit past the edge
  task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_word = word;
    req_src1 = a; req_src2 = b; req_tag = tag;
    #1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    sb_t  e;
    int   lat;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_word = 1'b0;
    req_src1 = '0; req_src2 = '0; req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
    mul_ok = 1'b0; mul_res_high = '0; mul_res_low = '0;
    div_ready = 1'b0; div_quo = '0; div_rem = '0;

    add(OP_MUL, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd11, U_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 1,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, 1);
    add(OP_MULHU, 0, '1, '1, 5'd3, U_MUL, '1, '1, 0, 0,
        64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    add(OP_MUL, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd20, U_MUL, 64'h0000_0000_7FFF_FFFF, 64'd2, 1, 1,
        64'd0, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    add(OP_MULHSU, 0, '1, 64'd2, 5'd21, U_MUL, '1, 64'd2, 1, 0,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(OP_DIV, 1, 64'd5, 64'd0, 5'd7, U_FAST, 64'd5, 64'd0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(OP_REM, 1, 64'd5, 64'd0, 5'd8, U_FAST, 64'd5, 64'd0, 1, 0, 0, 0, 64'd5, 0);
    add(OP_DIV, 1, 64'd5, 64'hABCD_0000_0000_0000, 5'd9, U_FAST, 64'd5, 64'd0, 1, 0, 0, 0, '1, 0);
    add(OP_DIV, 0, XLEN_MIN_64, '1, 5'd12, U_FAST, XLEN_MIN_64, '1, 1, 0, 0, 0, XLEN_MIN_64, 0);
    add(OP_REM, 0, XLEN_MIN_64, '1, 5'd13, U_FAST, XLEN_MIN_64, '1, 1, 0, 0, 0, 64'd0, 0);
    add(OP_DIV, 1, 64'h0000_0000_8000_0000, '1, 5'd14, U_FAST, 64'hFFFF_FFFF_8000_0000, '1, 1, 0,
        0, 0, 64'hFFFF_FFFF_8000_0000, 0);
    add(OP_DIVU, 0, 64'd123, 64'd0, 5'd15, U_FAST, 64'd123, 64'd0, 0, 0, 0, 0, '1, 0);
    add(OP_REM, 0, 64'd123, 64'd0, 5'd16, U_FAST, 64'd123, 64'd0, 1, 0, 0, 0, 64'd123, 0);
    add(OP_REMU, 1, 64'h0000_0000_8000_0001, 64'd0, 5'd17, U_FAST, 64'h0000_0000_8000_0001, 64'd0, 0, 0,
        0, 0, 64'hFFFF_FFFF_8000_0001, 0);
    add(OP_REMU, 0, 64'd100, 64'd7, 5'd18, U_DIV, 64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 64'd2, 5);
    add(OP_DIVU, 1, 64'hDEAD_0000_8000_0010, 64'h1234_0000_0000_0002, 5'd19, U_DIV,
        64'h0000_0000_8000_0010, 64'd2, 0, 0, 64'h0000_0000_4000_0008, 64'd0, 64'h0000_0000_4000_0008, 0);
    add(OP_REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd22, U_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0,
        64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF, '1, 0);

    repeat (3) tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_div_flush", div_flush, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_sign1", mul_sign1, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      issue(v.op, v.word, v.s1, v.s2, v.tag);
      e.res = v.res;
      e.tag = v.tag;
      sb.push_back(e);
      chk("mul_valid", mul_valid, v.unit == U_MUL);
      chk("div_valid", div_valid, v.unit == U_DIV);
      chk("resp_early", resp_valid, 0);
      if (v.unit == U_MUL) begin
        chk("mul_src1", mul_src1, v.e1);
        chk("mul_src2", mul_src2, v.e2);
        chk("mul_sign1", mul_sign1, v.sg1);
        chk("mul_sign2", mul_sign2, v.sg2);
        tick();
        chk("mul_valid_once", mul_valid, 0);
        tick();
        tick();
        mul_res_high = v.ua; mul_res_low = v.ub; mul_ok = 1'b1;
        tick();
        mul_ok = 1'b0;
      end else begin
        chk("div_src1", div_src1, v.e1);
        chk("div_src2", div_src2, v.e2);
        chk("div_sign", div_sign, v.sg1);
        if (v.unit == U_DIV) begin
          tick();
          chk("div_valid_once", div_valid, 0);
          tick();
          div_quo = v.ua; div_rem = v.ub; div_ready = 1'b1;
          tick();
          div_ready = 1'b0;
        end
      end
      lat = 0;
      while (!resp_valid && lat < 8) begin
        tick();
        lat++;
      end
      chk("resp_latency", lat, (v.unit == U_FAST) ? 1 : 0);
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      for (int h = 0; h < v.hold; h++) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_result", resp_result, e.res);
        chk("hold_req_ready", req_ready, 0);
        tick();
      end
      resp_ready = 1'b1;
      #1;
      chk("resp_valid", resp_valid, 1);
      chk("resp_result", resp_result, e.res);
      chk("resp_tag", resp_tag, e.tag);
      chk("no_same_cycle_accept", req_ready, 0);
      $display("vec %0d op=%b word=%0d result=%h tag=%0d", i, v.op, v.word, resp_result, resp_tag);
      tick();
      resp_ready = 1'b0;
      #1;
      chk("resp_drop", resp_valid, 0);
      chk("ready_after_hs", req_ready, 1);
    end

    // flush while the divider runs, with a coincident div_ready
    issue(OP_DIV, 0, 64'd100, 64'd7, 5'd1);
    chk("seqA_div_valid", div_valid, 1);
    tick();
    flush = 1'b1; div_ready = 1'b1; div_quo = 64'd14;
    #1;
    chk("seqA_div_flush", div_flush, 1);
    chk("seqA_req_ready_flush", req_ready, 0);
    tick();
    flush = 1'b0; div_ready = 1'b0;
    #1;
    chk("seqA_div_flush_once", div_flush, 0);
    chk("seqA_req_ready", req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      chk("seqA_no_resp", resp_valid, 0);
      tick();
    end
    $display("seq flush_div_wait done");

    // flush while the multiplier runs: drain until mul_ok, result dropped
    issue(OP_MUL, 0, 64'd2, 64'd3, 5'd2);
    chk("seqB_mul_valid", mul_valid, 1);
    tick();
    flush = 1'b1;
    #1;
    chk("seqB_req_ready_flush", req_ready, 0);
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      #1;
      chk("seqB_drain_ready", req_ready, 0);
      chk("seqB_drain_resp", resp_valid, 0);
      tick();
      flush = 1'b0;
    end
    mul_ok = 1'b1; mul_res_low = 64'd6;
    #1;
    chk("seqB_ready_at_ok", req_ready, 0);
    tick();
    mul_ok = 1'b0;
    #1;
    chk("seqB_ready_after", req_ready, 1);
    chk("seqB_resp_after", resp_valid, 0);
    tick();
    chk("seqB_resp_later", resp_valid, 0);
    $display("seq flush_mul_wait done");

    // flush in the launch cycle suppresses the start pulse
    issue(OP_MUL, 0, 64'd4, 64'd5, 5'd3);
    flush = 1'b1;
    #1;
    chk("seqC_no_mul_valid", mul_valid, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("seqC_ready", req_ready, 1);
    chk("seqC_mul_valid_after", mul_valid, 0);
    tick();
    $display("seq flush_launch done");

    // flush while a result is waiting
    issue(OP_DIV, 1, 64'd5, 64'd0, 5'd4);
    tick();
    chk("seqD_resp_valid", resp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("seqD_resp_dropped", resp_valid, 0);
    chk("seqD_ready", req_ready, 1);
    $display("seq flush_done done");

    // spurious unit completions in IDLE
    mul_ok = 1'b1; div_ready = 1'b1;
    tick();
    mul_ok = 1'b0; div_ready = 1'b0;
    #1;
    chk("seqE_resp", resp_valid, 0);
    chk("seqE_ready", req_ready, 1);
    $display("seq spurious done");

    // reset mid-divide overrides a coincident flush
    issue(OP_DIVU, 0, 64'd100, 64'd7, 5'd9);
    tick();
    rst = 1'b1; flush = 1'b1;
    #1;
    chk("seqF_no_div_flush", div_flush, 0);
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("seqF_ready", req_ready, 1);
    chk("seqF_resp", resp_valid, 0);
    chk("seqF_result", resp_result, 0);
    chk("seqF_tag", resp_tag, 0);
    $display("seq reset_mid_op done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
